// File: rtl/axil_uart_pkg.sv
// Shared constants and state encoding for the AXI-Lite UART bridge driver.
package axil_uart_pkg;

    localparam logic [7:0] REG_RX_FIFO = 8'h00;
    localparam logic [7:0] REG_TX_FIFO = 8'h04;
    localparam logic [7:0] REG_STAT    = 8'h08;
    localparam logic [7:0] REG_CTRL    = 8'h0C;

    localparam int STAT_RX_VALID = 0;
    localparam int STAT_TX_FULL  = 3;
    localparam int STAT_ERR_LSB  = 5;

    localparam logic [7:0] CTRL_RST_FIFOS = 8'h03;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [3:0] {
        ST_INIT_W,
        ST_INIT_B,
        ST_POLL_AR,
        ST_POLL_R,
        ST_RX_AR,
        ST_RX_R,
        ST_TX_W,
        ST_TX_B,
        ST_GAP
    } state_t;

endpackage

// File: rtl/axil_uart_driver.sv
// AXI4-Lite initiator that polls the UART bridge and turns its FIFOs into byte streams.
//
// state      | meaning
// INIT_W     | write CTRL=0x3 to flush both bridge FIFOs
// INIT_B     | wait for the CTRL write response
// POLL_AR    | read address phase of a STAT poll
// POLL_R     | STAT data phase; snapshot taken and next action chosen
// RX_AR      | read address phase of an RX FIFO read
// RX_R       | RX FIFO data phase; byte handed to rx_byte/rx_valid
// TX_W       | write pending byte to TX FIFO
// TX_B       | wait for the TX FIFO write response
// GAP        | idle countdown between polls
module axil_uart_driver
    import axil_uart_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_POLL_GAP         = 16,
    parameter int C_RESET_FIFOS      = 1
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [7:0]                      tx_byte,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic [7:0]                      rx_byte,
    output logic                            rx_valid,
    input  logic                            rx_ready,
    output logic [2:0]                      err_flags,
    output logic                            bus_err,
    input  logic                            err_clear,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int GAP_W = (C_POLL_GAP > 1) ? $clog2(C_POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (C_POLL_GAP > 0) ? GAP_W'(C_POLL_GAP - 1) : '0;
    localparam state_t ST_RESET = (C_RESET_FIFOS != 0) ? ST_INIT_W : ST_POLL_AR;
    localparam state_t ST_IDLE  = (C_POLL_GAP != 0) ? ST_GAP : ST_POLL_AR;

    state_t             state_q, state_d;
    logic               run_q;
    logic               aw_done_q, w_done_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic               snap_tx_full_q;
    logic [7:0]         rx_byte_q;
    logic               rx_valid_q;
    logic [7:0]         tx_byte_q;
    logic               tx_pending_q;
    logic [2:0]         err_flags_q;
    logic               bus_err_q;

    logic               is_w;
    logic               aw_hs, w_hs, ar_hs, r_hs, b_hs, w_all;
    logic               r_ok;
    logic [2:0]         new_flags;
    logic               new_bus_err;
    logic               unused_rdata;

    // run_q keeps every VALID low while in reset and for the first cycle after release
    assign is_w          = (state_q == ST_INIT_W) || (state_q == ST_TX_W);
    assign M_AXI_AWVALID = run_q && is_w && !aw_done_q;
    assign M_AXI_WVALID  = run_q && is_w && !w_done_q;
    assign M_AXI_AWADDR  = (state_q == ST_INIT_W) ? C_S_AXI_ADDR_WIDTH'(REG_CTRL)
                                                  : C_S_AXI_ADDR_WIDTH'(REG_TX_FIFO);
    assign M_AXI_WDATA   = (state_q == ST_INIT_W) ? C_S_AXI_DATA_WIDTH'(CTRL_RST_FIFOS)
                                                  : C_S_AXI_DATA_WIDTH'(tx_byte_q);
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_BREADY  = (state_q == ST_INIT_B) || (state_q == ST_TX_B);
    assign M_AXI_ARVALID = run_q && ((state_q == ST_POLL_AR) || (state_q == ST_RX_AR));
    assign M_AXI_ARADDR  = (state_q == ST_RX_AR) ? C_S_AXI_ADDR_WIDTH'(REG_RX_FIFO)
                                                 : C_S_AXI_ADDR_WIDTH'(REG_STAT);
    assign M_AXI_RREADY  = (state_q == ST_POLL_R) || (state_q == ST_RX_R);

    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
    assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_hs  = M_AXI_RVALID && M_AXI_RREADY;
    assign b_hs  = M_AXI_BVALID && M_AXI_BREADY;
    assign w_all = (aw_done_q || aw_hs) && (w_done_q || w_hs);
    assign r_ok  = (M_AXI_RRESP == RESP_OKAY);

    assign new_flags   = ((state_q == ST_POLL_R) && r_hs && r_ok)
                         ? M_AXI_RDATA[STAT_ERR_LSB +: 3] : 3'b000;
    assign new_bus_err = (r_hs && !r_ok) || (b_hs && (M_AXI_BRESP != RESP_OKAY));
    assign unused_rdata = &{1'b0, M_AXI_RDATA[C_S_AXI_DATA_WIDTH-1:8]};

    assign tx_ready  = !tx_pending_q;
    assign rx_byte   = rx_byte_q;
    assign rx_valid  = rx_valid_q;
    assign err_flags = err_flags_q;
    assign bus_err   = bus_err_q;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT_W:  if (w_all) state_d = ST_INIT_B;
            ST_INIT_B:  if (b_hs)  state_d = ST_POLL_AR;
            ST_POLL_AR: if (ar_hs) state_d = ST_POLL_R;
            ST_POLL_R: begin
                if (r_hs) begin
                    if (!r_ok)
                        state_d = ST_IDLE;
                    else if (M_AXI_RDATA[STAT_RX_VALID] && !rx_valid_q)
                        state_d = ST_RX_AR;
                    else if (tx_pending_q && !M_AXI_RDATA[STAT_TX_FULL])
                        state_d = ST_TX_W;
                    else
                        state_d = ST_IDLE;
                end
            end
            ST_RX_AR:   if (ar_hs) state_d = ST_RX_R;
            // TX room is judged from the poll snapshot; only this block fills the TX FIFO
            ST_RX_R:    if (r_hs)  state_d = (tx_pending_q && !snap_tx_full_q) ? ST_TX_W : ST_IDLE;
            ST_TX_W:    if (w_all) state_d = ST_TX_B;
            ST_TX_B:    if (b_hs)  state_d = ST_IDLE;
            ST_GAP:     if (gap_cnt_q == '0) state_d = ST_POLL_AR;
            default:    state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            run_q          <= 1'b0;
            aw_done_q      <= 1'b0;
            w_done_q       <= 1'b0;
            gap_cnt_q      <= '0;
            snap_tx_full_q <= 1'b0;
            rx_byte_q      <= 8'h00;
            rx_valid_q     <= 1'b0;
            tx_byte_q      <= 8'h00;
            tx_pending_q   <= 1'b0;
            err_flags_q    <= 3'b000;
            bus_err_q      <= 1'b0;
        end else begin
            run_q <= 1'b1;

            aw_done_q <= (is_w && !w_all) ? (aw_done_q || aw_hs) : 1'b0;
            w_done_q  <= (is_w && !w_all) ? (w_done_q || w_hs) : 1'b0;

            if ((state_d == ST_GAP) && (state_q != ST_GAP))
                gap_cnt_q <= GAP_LOAD;
            else if ((state_q == ST_GAP) && (gap_cnt_q != '0))
                gap_cnt_q <= gap_cnt_q - 1'b1;

            if ((state_q == ST_POLL_R) && r_hs)
                snap_tx_full_q <= M_AXI_RDATA[STAT_TX_FULL];

            if ((state_q == ST_RX_R) && r_hs && r_ok) begin
                rx_byte_q  <= M_AXI_RDATA[7:0];
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            if (tx_valid && !tx_pending_q) begin
                tx_byte_q    <= tx_byte;
                tx_pending_q <= 1'b1;
            end else if ((state_q == ST_TX_B) && b_hs) begin
                tx_pending_q <= 1'b0;
            end

            err_flags_q <= (err_clear ? 3'b000 : err_flags_q) | new_flags;
            bus_err_q   <= (bus_err_q && !err_clear) || new_bus_err;
        end
    end

endmodule

// File: tb/tb_axil_uart_driver.sv
// Bench for axil_uart_driver: reactive bridge model plus queue-based bus and RX scoreboards.
module tb_axil_uart_driver;

    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int GAP = 4;

    logic          S_AXI_ACLK = 1'b0;
    logic          S_AXI_ARESETN = 1'b0;
    logic [7:0]    tx_byte;
    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_ready;
    logic [2:0]    err_flags;
    logic          bus_err;
    logic          err_clear;
    logic [AW-1:0] M_AXI_AWADDR;
    logic          M_AXI_AWVALID, M_AXI_AWREADY;
    logic [DW-1:0] M_AXI_WDATA;
    logic [DW/8-1:0] M_AXI_WSTRB;
    logic          M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]    M_AXI_BRESP;
    logic          M_AXI_BVALID, M_AXI_BREADY;
    logic [AW-1:0] M_AXI_ARADDR;
    logic          M_AXI_ARVALID, M_AXI_ARREADY;
    logic [DW-1:0] M_AXI_RDATA;
    logic [1:0]    M_AXI_RRESP;
    logic          M_AXI_RVALID, M_AXI_RREADY;

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    axil_uart_driver #(
        .C_S_AXI_ADDR_WIDTH(AW),
        .C_S_AXI_DATA_WIDTH(DW),
        .C_POLL_GAP(GAP),
        .C_RESET_FIFOS(1)
    ) dut (
        .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESETN(S_AXI_ARESETN),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .err_flags(err_flags), .bus_err(bus_err), .err_clear(err_clear),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    // bridge model: STAT[0] reflects its own RX queue, other STAT bits come from stat_base
    logic [7:0] stat_base;
    int         aw_delay;
    logic [1:0] bresp_cfg, rresp_cfg;
    logic [7:0] slv_rx_q[$];
    int         aw_cnt;
    logic       aw_got, w_got, bvalid_r, rvalid_r;
    logic [1:0] bresp_r, rresp_r;
    logic [31:0] rdata_r;

    assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_delay);
    assign M_AXI_WREADY  = 1'b1;
    assign M_AXI_ARREADY = 1'b1;
    assign M_AXI_BVALID  = bvalid_r;
    assign M_AXI_BRESP   = bresp_r;
    assign M_AXI_RVALID  = rvalid_r;
    assign M_AXI_RRESP   = rresp_r;
    assign M_AXI_RDATA   = rdata_r;

    always @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            bvalid_r <= 1'b0; bresp_r <= 2'b00;
            rvalid_r <= 1'b0; rresp_r <= 2'b00; rdata_r <= 32'h0;
        end else begin
            if (M_AXI_AWVALID && !M_AXI_AWREADY) aw_cnt <= aw_cnt + 1;
            else if (M_AXI_AWVALID && M_AXI_AWREADY) aw_cnt <= 0;
            if (M_AXI_AWVALID && M_AXI_AWREADY) aw_got <= 1'b1;
            if (M_AXI_WVALID && M_AXI_WREADY) w_got <= 1'b1;
            if ((aw_got || (M_AXI_AWVALID && M_AXI_AWREADY)) &&
                (w_got || (M_AXI_WVALID && M_AXI_WREADY))) begin
                aw_got <= 1'b0; w_got <= 1'b0;
                bvalid_r <= 1'b1; bresp_r <= bresp_cfg;
            end else if (bvalid_r && M_AXI_BREADY) begin
                bvalid_r <= 1'b0;
            end
            if (M_AXI_ARVALID) begin
                rvalid_r <= 1'b1;
                rresp_r  <= rresp_cfg;
                if (M_AXI_ARADDR == 4'h8)
                    rdata_r <= {24'h0, stat_base[7:1], slv_rx_q.size() != 0};
                else if (M_AXI_ARADDR == 4'h0 && slv_rx_q.size() != 0)
                    rdata_r <= {24'h0, slv_rx_q.pop_front()};
                else
                    rdata_r <= 32'h0;
            end else if (rvalid_r && M_AXI_RREADY) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    typedef struct packed {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] data;
    } op_t;

    op_t        exp_ops[$];
    logic [7:0] exp_rx[$];
    int checks = 0, failures = 0;
    int cyc = 0, stat_cnt = 0, wr_cnt = 0, rxrd_cnt = 0, b_cnt = 0, rxhs_cnt = 0;
    int last_stat_cyc = 0, stat_period = 0;
    logic       aw_seen = 1'b0, w_seen = 1'b0;
    logic [3:0] aw_addr_m;
    logic [7:0] w_data_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic compare_op(input op_t act);
        if (exp_ops.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_bus_op: got 0x%0h expected none", act);
        end else begin
            check("bus_op", act, exp_ops.pop_front());
        end
    endtask

    always @(posedge S_AXI_ACLK) cyc++;

    always @(negedge S_AXI_ACLK) begin
        if (S_AXI_ARESETN) begin
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                aw_addr_m = M_AXI_AWADDR;
                aw_seen = 1'b1;
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                w_data_m = M_AXI_WDATA[7:0];
                w_seen = 1'b1;
                check("wstrb", M_AXI_WSTRB, 4'hF);
            end
            if (aw_seen && w_seen) begin
                aw_seen = 1'b0;
                w_seen = 1'b0;
                wr_cnt++;
                compare_op({1'b1, aw_addr_m, w_data_m});
            end
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                if (M_AXI_ARADDR == 4'h8) begin
                    if (stat_cnt > 0) stat_period = cyc - last_stat_cyc;
                    last_stat_cyc = cyc;
                    stat_cnt++;
                end else begin
                    rxrd_cnt++;
                    compare_op({1'b0, M_AXI_ARADDR, 8'h00});
                end
            end
            if (M_AXI_BVALID && M_AXI_BREADY) b_cnt++;
            if (rx_valid && rx_ready) begin
                rxhs_cnt++;
                if (exp_rx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rx: got 0x%0h expected none", rx_byte);
                end else begin
                    check("rx_byte", rx_byte, exp_rx.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge S_AXI_ACLK);
        #1;
    endtask

    task automatic wait_polls(input int n);
        int tgt = stat_cnt + n;
        for (int i = 0; i < 400 && stat_cnt < tgt; i++) tick();
        check("wait_polls", stat_cnt >= tgt, 1);
    endtask

    task automatic wait_tx_ready();
        for (int i = 0; i < 400 && !tx_ready; i++) tick();
        check("wait_tx_ready", tx_ready, 1);
    endtask

    task automatic wait_rxhs(input int tgt);
        for (int i = 0; i < 400 && rxhs_cnt < tgt; i++) tick();
        check("wait_rx_handshake", rxhs_cnt >= tgt, 1);
    endtask

    task automatic wait_drained();
        for (int i = 0; i < 400 && exp_ops.size() != 0; i++) tick();
        check("bus_ops_drained", exp_ops.size(), 0);
    endtask

    task automatic send_tx(input logic [7:0] b);
        tx_byte = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    initial begin
        int w0, r0, h0, b0;
        tx_byte = 8'h00; tx_valid = 1'b0; rx_ready = 1'b1; err_clear = 1'b0;
        stat_base = 8'h00; aw_delay = 0; bresp_cfg = 2'b00; rresp_cfg = 2'b00;
        exp_ops.push_back({1'b1, 4'hC, 8'h03});
        repeat (3) tick();

        check("rst_awvalid", M_AXI_AWVALID, 0);
        check("rst_wvalid", M_AXI_WVALID, 0);
        check("rst_arvalid", M_AXI_ARVALID, 0);
        check("rst_bready", M_AXI_BREADY, 0);
        check("rst_rready", M_AXI_RREADY, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_err_flags", err_flags, 0);
        check("rst_bus_err", bus_err, 0);
        S_AXI_ARESETN = 1'b1;

        // init flush, then steady poll cadence
        wait_drained();
        wait_polls(3);
        check("poll_period", stat_period, GAP + 2);

        // single RX byte
        slv_rx_q.push_back(8'h81);
        exp_ops.push_back({1'b0, 4'h0, 8'h00});
        exp_rx.push_back(8'h81);
        wait_rxhs(1);
        check("rx_reads", rxrd_cnt, 1);
        check("rx_valid_cleared", rx_valid, 0);

        // TX byte with room in the FIFO
        stat_base = 8'h04;
        check("tx_ready_idle", tx_ready, 1);
        b0 = b_cnt;
        w0 = wr_cnt;
        exp_ops.push_back({1'b1, 4'h4, 8'h55});
        send_tx(8'h55);
        check("tx_ready_busy", tx_ready, 0);
        wait_tx_ready();
        check("tx_ready_after_b", b_cnt, b0 + 1);
        check("tx_write_count", wr_cnt, w0 + 1);

        // TX FIFO full holds the byte back
        stat_base = 8'h08;
        wait_polls(1);
        w0 = wr_cnt;
        send_tx(8'hAA);
        wait_polls(3);
        check("no_write_when_full", wr_cnt, w0);
        check("tx_ready_held", tx_ready, 0);
        exp_ops.push_back({1'b1, 4'h4, 8'hAA});
        stat_base = 8'h00;
        wait_tx_ready();
        wait_polls(2);
        check("single_write_after_full", wr_cnt, w0 + 1);

        // RX backpressure: one read only until the byte is taken
        rx_ready = 1'b0;
        r0 = rxrd_cnt;
        h0 = rxhs_cnt;
        slv_rx_q.push_back(8'h81);
        slv_rx_q.push_back(8'h42);
        exp_ops.push_back({1'b0, 4'h0, 8'h00});
        exp_rx.push_back(8'h81);
        exp_rx.push_back(8'h42);
        wait_polls(4);
        check("rx_reads_held", rxrd_cnt, r0 + 1);
        check("rx_valid_held", rx_valid, 1);
        check("rx_byte_held", rx_byte, 8'h81);
        exp_ops.push_back({1'b0, 4'h0, 8'h00});
        rx_ready = 1'b1;
        wait_rxhs(h0 + 2);
        check("rx_reads_resumed", rxrd_cnt, r0 + 2);

        // slow AWREADY, SLVERR response, overrun flag in STAT
        stat_base = 8'h20;
        wait_polls(2);
        aw_delay = 3;
        bresp_cfg = 2'b10;
        exp_ops.push_back({1'b1, 4'h4, 8'h77});
        send_tx(8'h77);
        for (int i = 0; i < 100 && !M_AXI_AWVALID; i++) tick();
        check("awvalid_seen", M_AXI_AWVALID, 1);
        tick();
        check("wvalid_dropped", M_AXI_WVALID, 0);
        check("awvalid_held", M_AXI_AWVALID, 1);
        wait_tx_ready();
        check("bus_err_set", bus_err, 1);
        check("err_flags_set", err_flags, 3'b001);
        stat_base = 8'h00;
        aw_delay = 0;
        bresp_cfg = 2'b00;
        wait_polls(2);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("bus_err_cleared", bus_err, 0);
        check("err_flags_cleared", err_flags, 0);
        wait_polls(1);
        check("err_flags_stay_clear", err_flags, 0);

        wait_drained();
        check("rx_queue_drained", exp_rx.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
